fractal_axi_regs: RTL and testbench

FRACTAL_AXI_REGS -- requirements
Module: fractal_axi_regs

---
 rtl/fractal_axi_regs_if.sv | 36 +++
 rtl/fractal_axi_regs.sv | 164 ++++++++++++++++
 tb/tb_fractal_axi_regs.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fractal_axi_regs_if.sv
// AXI4-Lite slave bundle carrying the write, response and read channels of the register block.
interface fractal_axi_regs_if #(
    parameter int unsigned ADDR_WIDTH = 8
) ();
    logic [ADDR_WIDTH-1:0] s_axi_awaddr;
    logic                  s_axi_awvalid;
    logic                  s_axi_awready;
    logic [31:0]           s_axi_wdata;
    logic [3:0]            s_axi_wstrb;
    logic                  s_axi_wvalid;
    logic                  s_axi_wready;
    logic [1:0]            s_axi_bresp;
    logic                  s_axi_bvalid;
    logic                  s_axi_bready;
    logic [ADDR_WIDTH-1:0] s_axi_araddr;
    logic                  s_axi_arvalid;
    logic                  s_axi_arready;
    logic [31:0]           s_axi_rdata;
    logic [1:0]            s_axi_rresp;
    logic                  s_axi_rvalid;
    logic                  s_axi_rready;

    modport slave (
        input  s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
        input  s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
        output s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
        output s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
    );

    modport master (
        output s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
        output s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
        input  s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
        input  s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
    );
endinterface

// File: rtl/fractal_axi_regs.sv
// Four 32-bit AXI4-Lite read/write registers with independent AW/W holding, byte strobes
// and a per-register write pulse. All channel outputs, including the ready signals, are flops.
module fractal_axi_regs #(
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    fractal_axi_regs_if.slave      axi,
    output logic [127:0]           registers,
    output logic [3:0]             wr_pulse
);
    localparam int unsigned NUM_REGS   = 4;
    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned STRB_WIDTH = 4;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    // Registered state
    logic                                  aw_held_q, aw_held_d;
    logic [ADDR_WIDTH-1:0]                 aw_addr_q, aw_addr_d;
    logic                                  w_held_q, w_held_d;
    logic [DATA_WIDTH-1:0]                 w_data_q, w_data_d;
    logic [STRB_WIDTH-1:0]                 w_strb_q, w_strb_d;
    logic                                  awready_q, awready_d;
    logic                                  wready_q, wready_d;
    logic                                  bvalid_q, bvalid_d;
    logic [1:0]                            bresp_q, bresp_d;
    logic                                  arready_q, arready_d;
    logic                                  rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0]                 rdata_q, rdata_d;
    logic [1:0]                            rresp_q, rresp_d;
    logic [NUM_REGS-1:0][DATA_WIDTH-1:0]   reg_q, reg_d;
    logic [NUM_REGS-1:0]                   wr_pulse_q, wr_pulse_d;

    // Handshake and commit decode
    logic                  aw_hs, w_hs, ar_hs;
    logic                  have_aw, have_w, commit;
    logic [ADDR_WIDTH-1:0] cm_addr;
    logic [DATA_WIDTH-1:0] cm_data;
    logic [STRB_WIDTH-1:0] cm_strb;
    logic                  cm_in_range, ar_in_range;
    logic [1:0]            cm_idx, ar_idx;

    assign aw_hs   = axi.s_axi_awvalid & awready_q;
    assign w_hs    = axi.s_axi_wvalid  & wready_q;
    assign ar_hs   = axi.s_axi_arvalid & arready_q;
    assign have_aw = aw_held_q | aw_hs;
    assign have_w  = w_held_q  | w_hs;
    assign commit  = have_aw & have_w;

    // A held beat takes priority; otherwise the beat handshaking this cycle is used directly.
    assign cm_addr = aw_held_q ? aw_addr_q : axi.s_axi_awaddr;
    assign cm_data = w_held_q  ? w_data_q  : axi.s_axi_wdata;
    assign cm_strb = w_held_q  ? w_strb_q  : axi.s_axi_wstrb;

    // Anything above the 16-byte window is out of range; shifting keeps ADDR_WIDTH == 4 legal.
    assign cm_in_range = ((cm_addr >> 4) == '0);
    assign ar_in_range = ((axi.s_axi_araddr >> 4) == '0);
    assign cm_idx      = cm_addr[3:2];
    assign ar_idx      = axi.s_axi_araddr[3:2];

    // Next-state logic for write holding, commit, response and read channels
    always_comb begin
        aw_held_d  = aw_held_q;
        aw_addr_d  = aw_addr_q;
        w_held_d   = w_held_q;
        w_data_d   = w_data_q;
        w_strb_d   = w_strb_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        rvalid_d   = rvalid_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        reg_d      = reg_q;
        wr_pulse_d = '0;

        if (aw_hs) begin
            aw_addr_d = axi.s_axi_awaddr;
        end
        if (w_hs) begin
            w_data_d = axi.s_axi_wdata;
            w_strb_d = axi.s_axi_wstrb;
        end
        aw_held_d = have_aw & ~commit;
        w_held_d  = have_w  & ~commit;

        if (commit) begin
            bvalid_d = 1'b1;
            bresp_d  = cm_in_range ? RESP_OKAY : RESP_SLVERR;
            if (cm_in_range) begin
                for (int b = 0; b < int'(STRB_WIDTH); b++) begin
                    if (cm_strb[b]) begin
                        reg_d[cm_idx][8*b +: 8] = cm_data[8*b +: 8];
                    end
                end
                wr_pulse_d[cm_idx] = |cm_strb;
            end
        end else if (bvalid_q && axi.s_axi_bready) begin
            bvalid_d = 1'b0;
        end

        // Reads sample the pre-commit register value when they coincide with a write.
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = ar_in_range ? reg_q[ar_idx] : '0;
            rresp_d  = ar_in_range ? RESP_OKAY : RESP_SLVERR;
        end else if (rvalid_q && axi.s_axi_rready) begin
            rvalid_d = 1'b0;
        end

        awready_d = ~aw_held_d & ~bvalid_d;
        wready_d  = ~w_held_d  & ~bvalid_d;
        arready_d = ~rvalid_d;
    end

    // State registers; readies come up only on the first edge after reset release
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            aw_held_q  <= 1'b0;
            aw_addr_q  <= '0;
            w_held_q   <= 1'b0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= '0;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= '0;
            reg_q      <= '0;
            wr_pulse_q <= '0;
        end else begin
            aw_held_q  <= aw_held_d;
            aw_addr_q  <= aw_addr_d;
            w_held_q   <= w_held_d;
            w_data_q   <= w_data_d;
            w_strb_q   <= w_strb_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            reg_q      <= reg_d;
            wr_pulse_q <= wr_pulse_d;
        end
    end

    // Output wiring straight from the flops
    assign axi.s_axi_awready = awready_q;
    assign axi.s_axi_wready  = wready_q;
    assign axi.s_axi_bvalid  = bvalid_q;
    assign axi.s_axi_bresp   = bresp_q;
    assign axi.s_axi_arready = arready_q;
    assign axi.s_axi_rvalid  = rvalid_q;
    assign axi.s_axi_rdata   = rdata_q;
    assign axi.s_axi_rresp   = rresp_q;
    assign registers         = reg_q;
    assign wr_pulse          = wr_pulse_q;
endmodule

// File: tb/tb_fractal_axi_regs.sv
// Self-checking bench for fractal_axi_regs: directed vector table, multi-cycle corner
// sequences and randomized traffic against a byte-mask register model.
module tb_fractal_axi_regs;
    localparam int unsigned AW = 8;

    logic         aclk = 1'b0;
    logic         aresetn = 1'b0;
    logic [127:0] registers;
    logic [3:0]   wr_pulse;

    fractal_axi_regs_if #(.ADDR_WIDTH(AW)) axi ();

    fractal_axi_regs #(.ADDR_WIDTH(AW)) dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .axi       (axi.slave),
        .registers (registers),
        .wr_pulse  (wr_pulse)
    );

    always #5 aclk = ~aclk;

    int checks = 0;
    int errors = 0;
    logic [31:0] model [4];

    typedef struct {
        logic          is_wr;
        logic [AW-1:0] addr;
        logic [31:0]   data;   // write data, or expected rdata for reads
        logic [3:0]    strb;
        logic [1:0]    resp;
        logic [3:0]    pulse;
    } vec_t;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] model_bus();
        return {model[3], model[2], model[1], model[0]};
    endfunction

    function automatic logic addr_ok(input logic [AW-1:0] a);
        return int'(a) < 16;
    endfunction

    task automatic model_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] mask;
        mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        if (addr_ok(a)) model[int'(a) / 4] = (model[int'(a) / 4] & ~mask) | (d & mask);
    endtask

    task automatic idle_bus();
        axi.s_axi_awaddr = '0; axi.s_axi_awvalid = 1'b0;
        axi.s_axi_wdata = '0;  axi.s_axi_wstrb = '0; axi.s_axi_wvalid = 1'b0;
        axi.s_axi_bready = 1'b0;
        axi.s_axi_araddr = '0; axi.s_axi_arvalid = 1'b0; axi.s_axi_rready = 1'b0;
    endtask

    // Full write: AW and W presented after independent delays, B accepted at once.
    task automatic axi_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int awd, input int wd,
                             output logic [1:0] resp, output logic [3:0] pulse,
                             output logic ok, output int lat);
        logic aw_done, w_done, aw_go, w_go;
        int cyc;
        aw_done = 1'b0; w_done = 1'b0; cyc = 0; lat = 0;
        @(negedge aclk);
        axi.s_axi_bready = 1'b1;
        while (!(aw_done && w_done) && cyc < 40) begin
            axi.s_axi_awaddr  = a;
            axi.s_axi_awvalid = !aw_done && cyc >= awd;
            axi.s_axi_wdata   = d;
            axi.s_axi_wstrb   = s;
            axi.s_axi_wvalid  = !w_done && cyc >= wd;
            aw_go = axi.s_axi_awvalid && axi.s_axi_awready;
            w_go  = axi.s_axi_wvalid && axi.s_axi_wready;
            @(posedge aclk);
            @(negedge aclk);
            if (aw_go) aw_done = 1'b1;
            if (w_go) w_done = 1'b1;
            cyc++;
        end
        axi.s_axi_awvalid = 1'b0;
        axi.s_axi_wvalid  = 1'b0;
        while (!axi.s_axi_bvalid && lat < 20) begin
            @(negedge aclk);
            lat++;
        end
        ok    = aw_done && w_done && axi.s_axi_bvalid;
        resp  = axi.s_axi_bresp;
        pulse = wr_pulse;
        @(negedge aclk);
    endtask

    task automatic axi_read(input logic [AW-1:0] a, output logic [31:0] d, output logic [1:0] resp,
                            output logic ok);
        logic go;
        int k;
        go = 1'b0; k = 0;
        @(negedge aclk);
        axi.s_axi_arvalid = 1'b1;
        axi.s_axi_araddr  = a;
        axi.s_axi_rready  = 1'b1;
        while (!go && k < 20) begin
            go = axi.s_axi_arready;
            @(posedge aclk);
            @(negedge aclk);
            k++;
        end
        axi.s_axi_arvalid = 1'b0;
        ok   = go && axi.s_axi_rvalid;
        d    = axi.s_axi_rdata;
        resp = axi.s_axi_rresp;
        @(negedge aclk);
    endtask

    initial begin
        vec_t        tbl [10];
        logic [1:0]  resp;
        logic [3:0]  pulse;
        logic [31:0] rd;
        logic [31:0] old;
        logic        ok;
        int          lat;

        tbl[0] = '{1'b1, 8'h00, 32'hF1F2F3F4, 4'hF, 2'b00, 4'h1};
        tbl[1] = '{1'b1, 8'h04, 32'hF5F6F7F8, 4'hF, 2'b00, 4'h2};
        tbl[2] = '{1'b1, 8'h08, 32'hF9FAFBFC, 4'hF, 2'b00, 4'h4};
        tbl[3] = '{1'b1, 8'h0C, 32'hFDFEFFF0, 4'hF, 2'b00, 4'h8};
        tbl[4] = '{1'b0, 8'h0C, 32'hFDFEFFF0, 4'h0, 2'b00, 4'h0};
        tbl[5] = '{1'b0, 8'h08, 32'hF9FAFBFC, 4'h0, 2'b00, 4'h0};
        tbl[6] = '{1'b0, 8'h04, 32'hF5F6F7F8, 4'h0, 2'b00, 4'h0};
        tbl[7] = '{1'b0, 8'h00, 32'hF1F2F3F4, 4'h0, 2'b00, 4'h0};
        tbl[8] = '{1'b1, 8'h10, 32'hDEADBEEF, 4'hF, 2'b10, 4'h0};
        tbl[9] = '{1'b0, 8'h20, 32'h00000000, 4'h0, 2'b10, 4'h0};

        for (int i = 0; i < 4; i++) model[i] = '0;
        idle_bus();

        // Reset state and ready release timing
        repeat (3) @(negedge aclk);
        chk("rst_awready", 128'(axi.s_axi_awready), 128'(0));
        chk("rst_wready", 128'(axi.s_axi_wready), 128'(0));
        chk("rst_arready", 128'(axi.s_axi_arready), 128'(0));
        chk("rst_regs", registers, 128'(0));
        chk("rst_valids", 128'({axi.s_axi_bvalid, axi.s_axi_rvalid, wr_pulse}), 128'(0));
        aresetn = 1'b1;
        #1;
        chk("release_ready_early", 128'({axi.s_axi_awready, axi.s_axi_wready, axi.s_axi_arready}), 128'(0));
        @(posedge aclk);
        #1;
        chk("release_ready_edge", 128'({axi.s_axi_awready, axi.s_axi_wready, axi.s_axi_arready}), 128'(3'b111));

        // Directed vector table
        for (int i = 0; i < 10; i++) begin
            if (tbl[i].is_wr) begin
                axi_write(tbl[i].addr, tbl[i].data, tbl[i].strb, 0, 0, resp, pulse, ok, lat);
                model_write(tbl[i].addr, tbl[i].data, tbl[i].strb);
                chk($sformatf("tbl%0d_ok", i), 128'(ok), 128'(1));
                chk($sformatf("tbl%0d_lat", i), 128'(lat), 128'(0));
                chk($sformatf("tbl%0d_bresp", i), 128'(resp), 128'(tbl[i].resp));
                chk($sformatf("tbl%0d_pulse", i), 128'(pulse), 128'(tbl[i].pulse));
                chk($sformatf("tbl%0d_regs", i), registers, model_bus());
                if (i == 3) chk("regs_after_four", registers,
                                128'hFDFEFFF0_F9FAFBFC_F5F6F7F8_F1F2F3F4);
            end else begin
                axi_read(tbl[i].addr, rd, resp, ok);
                chk($sformatf("tbl%0d_rvalid", i), 128'(ok), 128'(1));
                chk($sformatf("tbl%0d_rdata", i), 128'(rd), 128'(tbl[i].data));
                chk($sformatf("tbl%0d_rresp", i), 128'(resp), 128'(tbl[i].resp));
            end
        end

        // W three cycles ahead of AW, partial strobe
        @(negedge aclk);
        axi.s_axi_bready = 1'b1;
        axi.s_axi_wdata = 32'h12345678; axi.s_axi_wstrb = 4'b0101; axi.s_axi_wvalid = 1'b1;
        chk("early_w_ready", 128'(axi.s_axi_wready), 128'(1));
        @(posedge aclk);
        @(negedge aclk);
        axi.s_axi_wvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("early_w_wready_low", 128'(axi.s_axi_wready), 128'(0));
            chk("early_w_no_b", 128'(axi.s_axi_bvalid), 128'(0));
            if (i < 2) @(negedge aclk);
        end
        axi.s_axi_awaddr = 8'h04; axi.s_axi_awvalid = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        axi.s_axi_awvalid = 1'b0;
        model_write(8'h04, 32'h12345678, 4'b0101);
        chk("early_w_bvalid", 128'(axi.s_axi_bvalid), 128'(1));
        chk("early_w_bresp", 128'(axi.s_axi_bresp), 128'(0));
        chk("early_w_reg1", 128'(registers[63:32]), 128'(32'hF534F778));
        chk("early_w_pulse", 128'(wr_pulse), 128'(4'h2));
        @(negedge aclk);
        chk("pulse_one_cycle", 128'(wr_pulse), 128'(0));
        repeat (2) @(negedge aclk);
        chk("early_w_single_b", 128'(axi.s_axi_bvalid), 128'(0));

        // Back-pressured response blocks further writes
        axi.s_axi_bready = 1'b0;
        axi.s_axi_awaddr = 8'h08; axi.s_axi_awvalid = 1'b1;
        axi.s_axi_wdata = 32'hA5A5A5A5; axi.s_axi_wstrb = 4'hF; axi.s_axi_wvalid = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        model_write(8'h08, 32'hA5A5A5A5, 4'hF);
        axi.s_axi_awaddr = 8'h0C; axi.s_axi_wdata = 32'h11223344;
        for (int i = 0; i < 5; i++) begin
            chk("bp_bvalid_hold", 128'(axi.s_axi_bvalid), 128'(1));
            chk("bp_ready_low", 128'({axi.s_axi_awready, axi.s_axi_wready}), 128'(0));
            @(negedge aclk);
        end
        chk("bp_first_reg", registers, model_bus());
        axi.s_axi_bready = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        chk("bp_ready_after_hs", 128'({axi.s_axi_bvalid, axi.s_axi_awready, axi.s_axi_wready}), 128'(3'b011));
        @(posedge aclk);
        @(negedge aclk);
        axi.s_axi_awvalid = 1'b0; axi.s_axi_wvalid = 1'b0;
        model_write(8'h0C, 32'h11223344, 4'hF);
        chk("bp_second_bvalid", 128'(axi.s_axi_bvalid), 128'(1));
        chk("bp_second_regs", registers, model_bus());
        @(negedge aclk);

        // Read and commit to the same register in one cycle
        old = model[0];
        axi.s_axi_awaddr = 8'h00; axi.s_axi_awvalid = 1'b1;
        axi.s_axi_wdata = 32'hCAFEF00D; axi.s_axi_wstrb = 4'hF; axi.s_axi_wvalid = 1'b1;
        axi.s_axi_araddr = 8'h00; axi.s_axi_arvalid = 1'b1; axi.s_axi_rready = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        axi.s_axi_awvalid = 1'b0; axi.s_axi_wvalid = 1'b0; axi.s_axi_arvalid = 1'b0;
        model_write(8'h00, 32'hCAFEF00D, 4'hF);
        chk("rw_same_rvalid", 128'(axi.s_axi_rvalid), 128'(1));
        chk("rw_same_rdata", 128'(axi.s_axi_rdata), 128'(old));
        chk("rw_same_regs", registers, model_bus());
        @(negedge aclk);

        // Randomized traffic against the model
        for (int i = 0; i < 150; i++) begin
            logic [AW-1:0] a;
            logic [31:0]   d;
            logic [3:0]    s;
            int            sel;
            sel = int'($urandom_range(0, 9));
            if (sel < 4) a = AW'(sel * 4 + int'($urandom_range(0, 3)));
            else if (sel < 8) a = AW'((sel - 4) * 4);
            else a = AW'($urandom_range(16, 255));
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) begin
                axi_write(a, d, s, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                          resp, pulse, ok, lat);
                chk("rnd_wr_ok", 128'(ok), 128'(1));
                chk("rnd_bresp", 128'(resp), addr_ok(a) ? 128'(0) : 128'(2));
                chk("rnd_pulse", 128'(pulse),
                    (addr_ok(a) && s != 0) ? 128'(1 << (int'(a) / 4)) : 128'(0));
                model_write(a, d, s);
                chk("rnd_regs", registers, model_bus());
            end else begin
                axi_read(a, rd, resp, ok);
                chk("rnd_rd_ok", 128'(ok), 128'(1));
                chk("rnd_rdata", 128'(rd), addr_ok(a) ? 128'(model[int'(a) / 4]) : 128'(0));
                chk("rnd_rresp", 128'(resp), addr_ok(a) ? 128'(0) : 128'(2));
            end
        end

        // Reset between AW and W: nothing held survives
        @(negedge aclk);
        axi.s_axi_bready = 1'b1;
        axi.s_axi_awaddr = 8'h04; axi.s_axi_awvalid = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        axi.s_axi_awvalid = 1'b0;
        #2;
        aresetn = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) model[i] = '0;
        chk("midrst_regs", registers, model_bus());
        chk("midrst_bvalid", 128'(axi.s_axi_bvalid), 128'(0));
        chk("midrst_ready", 128'({axi.s_axi_awready, axi.s_axi_wready, axi.s_axi_arready}), 128'(0));
        @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        axi.s_axi_wdata = 32'h55AA55AA; axi.s_axi_wstrb = 4'hF; axi.s_axi_wvalid = 1'b1;
        chk("midrst_wready", 128'(axi.s_axi_wready), 128'(1));
        @(posedge aclk);
        @(negedge aclk);
        axi.s_axi_wvalid = 1'b0;
        repeat (5) @(negedge aclk);
        chk("midrst_w_alone_no_b", 128'(axi.s_axi_bvalid), 128'(0));
        chk("midrst_w_alone_regs", registers, model_bus());

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
